// File: rtl/df_pkg.sv
// Shared constants for the deblocking threshold generator: H.264 alpha/beta/tc0
// tables, the QP/index ceiling and the edge-direction encoding.
package df_pkg;

  localparam int QP_MAX = 51;

  typedef enum logic {
    EDGE_VER = 1'b0,
    EDGE_HOR = 1'b1
  } edge_dir_e;

  // Indexed by indexA / indexB (0..51)
  localparam logic [7:0] ALPHA_TAB [52] = '{
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
    4, 4, 5, 6, 7, 8, 9, 10, 12, 13, 15, 17, 20, 22, 25, 28,
    32, 36, 40, 45, 50, 56, 63, 71, 80, 90, 101, 113, 127, 144, 162, 182,
    203, 226, 255, 255
  };

  localparam logic [4:0] BETA_TAB [52] = '{
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
    2, 2, 2, 3, 3, 3, 3, 4, 4, 4, 6, 6, 7, 7, 8, 8,
    9, 9, 10, 10, 11, 11, 12, 12, 13, 13, 14, 14, 15, 15, 16, 16,
    17, 17, 18, 18
  };

  // Indexed by [indexA][bS-1]
  localparam logic [4:0] TC0_TAB [52][3] = '{
    '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0},
    '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0},
    '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 1},
    '{0, 0, 1}, '{0, 0, 1}, '{0, 0, 1}, '{0, 1, 1}, '{0, 1, 1}, '{1, 1, 1},
    '{1, 1, 1}, '{1, 1, 1}, '{1, 1, 1}, '{1, 1, 2}, '{1, 1, 2}, '{1, 1, 2},
    '{1, 1, 2}, '{1, 2, 3}, '{1, 2, 3}, '{2, 2, 3}, '{2, 2, 4}, '{2, 3, 4},
    '{2, 3, 4}, '{3, 3, 5}, '{3, 4, 6}, '{3, 4, 6}, '{4, 5, 7}, '{4, 5, 8},
    '{4, 6, 9}, '{5, 7, 10}, '{6, 8, 11}, '{6, 8, 13}, '{7, 10, 14}, '{8, 11, 16},
    '{9, 12, 18}, '{10, 13, 20}, '{11, 15, 23}, '{13, 17, 25}
  };

endpackage

// File: rtl/df_thr_rom.sv
// Combinational alpha/beta/tc0 lookup; the caller registers the results.
module df_thr_rom
  import df_pkg::*;
(
  input  logic [5:0] index_a,
  input  logic [5:0] index_b,
  input  logic [2:0] bs,
  output logic [7:0] alpha,
  output logic [4:0] beta,
  output logic [4:0] tc0
);

  logic [1:0] tc_col;

  always_comb begin
    alpha  = 8'd0;
    beta   = 5'd0;
    tc0    = 5'd0;
    tc_col = bs[1:0] - 2'd1;
    if (index_a <= 6'(QP_MAX)) alpha = ALPHA_TAB[index_a];
    if (index_b <= 6'(QP_MAX)) beta  = BETA_TAB[index_b];
    // bS 0 and bS 4 (strong filter) carry no tc0
    if (index_a <= 6'(QP_MAX) && bs >= 3'd1 && bs <= 3'd3)
      tc0 = TC0_TAB[index_a][tc_col];
  end

endmodule

// File: rtl/df_threshold_gen.sv
// Two-stage deblocking threshold pipeline: QP average and index clipping, then
// table lookup, with a valid/ready handshake that holds output under backpressure.
module df_threshold_gen
  import df_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [5:0]        QPy,
  input  logic [5:0]        QPc,
  input  logic [5:0]        QPy_addrA,
  input  logic [5:0]        QPc_addrA,
  input  logic [5:0]        QPy_addrB,
  input  logic [5:0]        QPc_addrB,
  input  logic signed [3:0] alpha_off_div2,
  input  logic signed [3:0] beta_off_div2,
  input  logic              req_valid,
  input  logic              edge_dir,
  input  logic [1:0]        edge_idx,
  input  logic              is_chroma,
  input  logic [2:0]        bS,
  input  logic              disable_flag,
  output logic              req_ready,
  output logic              thr_valid,
  output logic [7:0]        alpha,
  output logic [4:0]        beta,
  output logic [4:0]        tc0,
  output logic [2:0]        bS_out,
  output logic              filter_en,
  output logic              edge_dir_out,
  output logic [1:0]        edge_idx_out,
  output logic              is_chroma_out,
  input  logic              thr_ready
);

  function automatic logic signed [7:0] add_offset(input logic [6:0] qpav,
                                                    input logic signed [3:0] off_div2);
    return $signed({1'b0, qpav}) + $signed({off_div2[3], off_div2[3], off_div2[3], off_div2, 1'b0});
  endfunction

  function automatic logic [5:0] clip_index(input logic signed [7:0] v);
    if (v < 0)           return 6'd0;
    else if (v > QP_MAX) return 6'(QP_MAX);
    else                 return v[5:0];
  endfunction

  logic       vld_p1, vld_p2;
  logic       ld_p1, ld_p2, accept;
  logic [5:0] qp_p, qp_q;
  logic [6:0] qpav;
  logic [5:0] idx_a_p1, idx_b_p1;
  logic [2:0] bs_p1;
  logic       dis_p1, dir_p1, chroma_p1;
  logic [1:0] eidx_p1;
  logic [7:0] rom_alpha;
  logic [4:0] rom_beta, rom_tc0;

  // A stage loads when empty or when its content moves on this cycle
  assign ld_p2     = !vld_p2 || thr_ready;
  assign ld_p1     = !vld_p1 || ld_p2;
  assign accept    = req_valid && ld_p1;
  assign req_ready = ld_p1;
  assign thr_valid = vld_p2;

  always_comb begin
    qp_q = is_chroma ? QPc : QPy;
    qp_p = qp_q;
    if (edge_idx == 2'd0)
      qp_p = (edge_dir == EDGE_VER) ? (is_chroma ? QPc_addrA : QPy_addrA)
                                    : (is_chroma ? QPc_addrB : QPy_addrB);
    qpav = ({1'b0, qp_p} + {1'b0, qp_q} + 7'd1) >> 1;
  end

  // Stage 1: QP average, clipped indices, sideband
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1    <= 1'b0;
      idx_a_p1  <= '0;
      idx_b_p1  <= '0;
      bs_p1     <= '0;
      dis_p1    <= 1'b0;
      dir_p1    <= 1'b0;
      eidx_p1   <= '0;
      chroma_p1 <= 1'b0;
    end else if (ld_p1) begin
      vld_p1 <= req_valid;
      if (accept) begin
        idx_a_p1  <= clip_index(add_offset(qpav, alpha_off_div2));
        idx_b_p1  <= clip_index(add_offset(qpav, beta_off_div2));
        bs_p1     <= bS;
        dis_p1    <= disable_flag;
        dir_p1    <= edge_dir;
        eidx_p1   <= edge_idx;
        chroma_p1 <= is_chroma;
      end
    end
  end

  df_thr_rom u_rom (
    .index_a (idx_a_p1),
    .index_b (idx_b_p1),
    .bs      (bs_p1),
    .alpha   (rom_alpha),
    .beta    (rom_beta),
    .tc0     (rom_tc0)
  );

  // Stage 2: registered thresholds and filter enable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p2        <= 1'b0;
      alpha         <= '0;
      beta          <= '0;
      tc0           <= '0;
      bS_out        <= '0;
      filter_en     <= 1'b0;
      edge_dir_out  <= 1'b0;
      edge_idx_out  <= '0;
      is_chroma_out <= 1'b0;
    end else if (ld_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        alpha         <= rom_alpha;
        beta          <= rom_beta;
        tc0           <= rom_tc0;
        bS_out        <= bs_p1;
        filter_en     <= (bs_p1 != 3'd0) && !dis_p1 && (rom_alpha != 8'd0);
        edge_dir_out  <= dir_p1;
        edge_idx_out  <= eidx_p1;
        is_chroma_out <= chroma_p1;
      end
    end
  end

endmodule

// File: tb/tb_df_threshold_gen.sv
// Directed and randomized bench for df_threshold_gen with an in-order scoreboard.
module tb_df_threshold_gen;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [5:0]        QPy, QPc, QPy_addrA, QPc_addrA, QPy_addrB, QPc_addrB;
  logic signed [3:0] alpha_off_div2, beta_off_div2;
  logic              req_valid, edge_dir, is_chroma, disable_flag, req_ready;
  logic [1:0]        edge_idx;
  logic [2:0]        bS;
  logic              thr_valid, filter_en, edge_dir_out, is_chroma_out, thr_ready;
  logic [7:0]        alpha;
  logic [4:0]        beta, tc0;
  logic [2:0]        bS_out;
  logic [1:0]        edge_idx_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int delivered = 0;
  bit ready_low_seen = 0;
  bit prev_stall = 0;
  logic [26:0] held;
  logic [25:0] sb[$];

  int ALPHA_M [52] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,
    4,4,5,6,7,8,9,10,12,13,15,17,20,22,25,28,32,36,40,45,50,56,63,71,
    80,90,101,113,127,144,162,182,203,226,255,255};
  int BETA_M [52] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,
    2,2,2,3,3,3,3,4,4,4,6,6,7,7,8,8,9,9,10,10,11,11,12,12,
    13,13,14,14,15,15,16,16,17,17,18,18};
  int TC0_M [52][3] = '{'{0,0,0},'{0,0,0},'{0,0,0},'{0,0,0},'{0,0,0},'{0,0,0},
    '{0,0,0},'{0,0,0},'{0,0,0},'{0,0,0},'{0,0,0},'{0,0,0},'{0,0,0},'{0,0,0},
    '{0,0,0},'{0,0,0},'{0,0,0},'{0,0,1},'{0,0,1},'{0,0,1},'{0,0,1},'{0,1,1},
    '{0,1,1},'{1,1,1},'{1,1,1},'{1,1,1},'{1,1,1},'{1,1,2},'{1,1,2},'{1,1,2},
    '{1,1,2},'{1,2,3},'{1,2,3},'{2,2,3},'{2,2,4},'{2,3,4},'{2,3,4},'{3,3,5},
    '{3,4,6},'{3,4,6},'{4,5,7},'{4,5,8},'{4,6,9},'{5,7,10},'{6,8,11},'{6,8,13},
    '{7,10,14},'{8,11,16},'{9,12,18},'{10,13,20},'{11,15,23},'{13,17,25}};

  df_threshold_gen dut (
    .clk(clk), .reset_n(reset_n),
    .QPy(QPy), .QPc(QPc), .QPy_addrA(QPy_addrA), .QPc_addrA(QPc_addrA),
    .QPy_addrB(QPy_addrB), .QPc_addrB(QPc_addrB),
    .alpha_off_div2(alpha_off_div2), .beta_off_div2(beta_off_div2),
    .req_valid(req_valid), .edge_dir(edge_dir), .edge_idx(edge_idx),
    .is_chroma(is_chroma), .bS(bS), .disable_flag(disable_flag), .req_ready(req_ready),
    .thr_valid(thr_valid), .alpha(alpha), .beta(beta), .tc0(tc0), .bS_out(bS_out),
    .filter_en(filter_en), .edge_dir_out(edge_dir_out), .edge_idx_out(edge_idx_out),
    .is_chroma_out(is_chroma_out), .thr_ready(thr_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int clamp51(input int v);
    return (v < 0) ? 0 : ((v > 51) ? 51 : v);
  endfunction

  function automatic logic [25:0] model();
    int qc, qa, qb, qpp, qpav, ia, ib, a, b, t, bs;
    qc   = is_chroma ? QPc : QPy;
    qa   = is_chroma ? QPc_addrA : QPy_addrA;
    qb   = is_chroma ? QPc_addrB : QPy_addrB;
    qpp  = (edge_idx == 2'd0) ? (edge_dir ? qb : qa) : qc;
    qpav = (qpp + qc + 1) / 2;
    ia   = clamp51(qpav + 2 * int'(alpha_off_div2));
    ib   = clamp51(qpav + 2 * int'(beta_off_div2));
    bs   = int'(bS);
    a    = ALPHA_M[ia];
    b    = BETA_M[ib];
    t    = (bs >= 1 && bs <= 3) ? TC0_M[ia][bs-1] : 0;
    return {8'(a), 5'(b), 5'(t), bS, (bs != 0 && !disable_flag && a != 0),
            edge_dir, edge_idx, is_chroma};
  endfunction

  function automatic logic [25:0] obs();
    return {alpha, beta, tc0, bS_out, filter_en, edge_dir_out, edge_idx_out, is_chroma_out};
  endfunction

  // Output side: pop and compare on each handshake, check holding while stalled
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) chk("hold_stable", {thr_valid, obs()}, held);
      if (req_valid && !req_ready) ready_low_seen = 1;
      if (thr_valid && thr_ready) begin
        if (sb.size() == 0) chk("spurious_output", thr_valid, 0);
        else begin
          chk("scoreboard", obs(), sb.pop_front());
          delivered++;
        end
      end
      prev_stall = thr_valid && !thr_ready;
      held = {thr_valid, obs()};
    end
  end

  task automatic send();
    bit ok = 0;
    req_valid = 1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) begin
        sb.push_back(model());
        ok = 1;
      end
    end
    if (!ok) chk("send_timeout", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic set_req(input logic dir, input logic [1:0] idx, input logic chroma,
                         input logic [2:0] bs, input logic dis);
    edge_dir = dir; edge_idx = idx; is_chroma = chroma; bS = bs; disable_flag = dis;
  endtask

  task automatic send_rand();
    QPy = 6'($urandom_range(0, 51)); QPc = 6'($urandom_range(0, 51));
    QPy_addrA = 6'($urandom_range(0, 51)); QPc_addrA = 6'($urandom_range(0, 51));
    QPy_addrB = 6'($urandom_range(0, 51)); QPc_addrB = 6'($urandom_range(0, 51));
    alpha_off_div2 = 4'($urandom_range(0, 15));
    beta_off_div2  = 4'($urandom_range(0, 15));
    set_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0));
    send();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 50 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk(tag, sb.size(), 0);
  endtask

  task automatic latency(input string tag);
    chk({tag, "_lat1"}, thr_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_lat2"}, thr_valid, 1);
  endtask

  initial begin
    int c0, d0;
    reset_n = 0; req_valid = 0; thr_ready = 1;
    QPy = 0; QPc = 0; QPy_addrA = 0; QPc_addrA = 0; QPy_addrB = 0; QPc_addrB = 0;
    alpha_off_div2 = 0; beta_off_div2 = 0;
    set_req(0, 0, 0, 0, 0);
    #1;
    chk("rst_thr_valid", thr_valid, 0);
    chk("rst_outputs", obs(), 0);
    chk("rst_req_ready", req_ready, 1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    chk("post_rst_ready", req_ready, 1);

    // Vertical luma edge 0: qPav 26
    QPy = 28; QPy_addrA = 24; QPy_addrB = 40;
    set_req(0, 0, 0, 1, 0);
    send();
    latency("v_luma");
    chk("v_luma_alpha", alpha, 15);
    chk("v_luma_beta", beta, 6);
    chk("v_luma_tc0", tc0, 1);
    chk("v_luma_fen", filter_en, 1);
    drain("drain_v_luma");

    // Horizontal edge 0, index clipped at 51
    QPy = 51; QPy_addrB = 51; QPy_addrA = 0; alpha_off_div2 = 6;
    set_req(1, 0, 0, 3, 0);
    send();
    latency("clip_hi");
    chk("clip_hi_alpha", alpha, 255);
    chk("clip_hi_beta", beta, 18);
    chk("clip_hi_tc0", tc0, 25);
    alpha_off_div2 = 0;
    drain("drain_clip_hi");

    // Low QP: no filtering but still delivered
    QPy = 10; QPy_addrA = 10; QPy_addrB = 10;
    set_req(0, 0, 0, 2, 0);
    send();
    latency("low_qp");
    chk("low_qp_out", {alpha, beta, tc0, filter_en}, 0);
    drain("drain_low_qp");

    // Chroma bS 4, then disabled
    QPc = 30; QPc_addrA = 30; QPy = 5;
    set_req(0, 0, 1, 4, 0);
    send();
    latency("chroma_bs4");
    chk("chroma_bs4_tc0", tc0, 0);
    chk("chroma_bs4_alpha", alpha, 25);
    chk("chroma_bs4_fen", filter_en, 1);
    drain("drain_chroma");
    disable_flag = 1;
    send();
    latency("disabled");
    chk("disabled_fen", filter_en, 0);
    drain("drain_disabled");

    // Negative offsets clip at 0; QP inputs changed right after accept
    QPy = 6; QPy_addrA = 7; QPy_addrB = 8; alpha_off_div2 = -8; beta_off_div2 = -8;
    set_req(1, 2, 0, 2, 0);
    send();
    QPy = 63; QPy_addrA = 63; QPy_addrB = 63; alpha_off_div2 = 7; beta_off_div2 = 7;
    drain("drain_clip_lo");

    // Eight back-to-back with a three-cycle output stall
    ready_low_seen = 0;
    d0 = delivered;
    fork
      begin
        repeat (8) send_rand();
      end
      begin
        repeat (2) @(posedge clk);
        #1 thr_ready = 0;
        repeat (3) @(posedge clk);
        #1 thr_ready = 1;
      end
    join
    drain("drain_burst");
    chk("burst_ready_fell", ready_low_seen, 1);
    chk("burst_delivered", delivered - d0, 8);

    // Sustained one request per cycle
    c0 = cyc;
    repeat (20) send_rand();
    chk("throughput_cycles", cyc - c0, 20);
    drain("drain_stream");

    // Reset with two requests in flight
    thr_ready = 0;
    QPy = 30; QPy_addrA = 30;
    set_req(0, 0, 0, 1, 0);
    send();
    send();
    #2 reset_n = 0;
    #1;
    chk("midrst_thr_valid", thr_valid, 0);
    chk("midrst_ready", req_ready, 1);
    chk("midrst_outputs", obs(), 0);
    sb.delete();
    thr_ready = 1;
    @(posedge clk); #1 reset_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("no_stale_output", thr_valid, 0);
    end
    chk("post_midrst_ready", req_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
